// File: rtl/apb_gcd_if.sv
// ----------------------------------------------------------------------------
// apb_gcd_if -- APB bus bundle for apb_gcd_engine.
//   i_paddr   : address              i_psel/i_penable/i_pwrite : APB control
//   i_pwdata  : write data           o_prdata  : registered read data
//   o_pready  : transfer completion  o_pslverr : transfer error
// The slave modport is the engine side; the master modport is the bus driver.
// ----------------------------------------------------------------------------
interface apb_gcd_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_paddr;
  logic              i_psel;
  logic              i_penable;
  logic              i_pwrite;
  logic [DATA_W-1:0] i_pwdata;
  logic [DATA_W-1:0] o_prdata;
  logic              o_pready;
  logic              o_pslverr;

  modport slave (
    input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
    output o_prdata, o_pready, o_pslverr
  );

  modport master (
    output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
    input  o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/apb_gcd_engine.sv
// ----------------------------------------------------------------------------
// apb_gcd_engine -- APB-mapped subtractive GCD engine with a result FIFO.
//   clk   : single clock
//   rst   : asynchronous, active-high reset
//   bus   : APB slave (apb_gcd_if.slave), one wait state per transfer
//   o_irq : level interrupt, IRQ.DONE & CTRL.IRQ_EN
// Register map (word offsets on i_paddr[ADDR_W-1:2]):
//   0x00 CTRL   RW  [0] EN, [1] IRQ_EN, [2] FIFO_CLR (pulse, reads 0)
//   0x04 STATUS RO  [0] BUSY, [1] EMPTY, [2] FULL, [8+:CW] COUNT
//   0x08 OPA    RW  0x0C OPB RW
//   0x10 CMD    WO  [0] START
//   0x14 RESULT RO  read pops the FIFO
//   0x18 IRQ    RW1C [0] DONE
// ----------------------------------------------------------------------------
module apb_gcd_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int OPW    = 16,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  apb_gcd_if.slave    bus,
  output logic        o_irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = ADDR_W - 2;

  localparam logic [IW-1:0] A_CTRL   = IW'(0);
  localparam logic [IW-1:0] A_STATUS = IW'(1);
  localparam logic [IW-1:0] A_OPA    = IW'(2);
  localparam logic [IW-1:0] A_OPB    = IW'(3);
  localparam logic [IW-1:0] A_CMD    = IW'(4);
  localparam logic [IW-1:0] A_RESULT = IW'(5);
  localparam logic [IW-1:0] A_IRQ    = IW'(6);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_state_t;
  typedef enum logic       {E_IDLE, E_CALC}     eng_state_t;

  apb_state_t        r_apb_state, w_apb_next;
  eng_state_t        r_e_state, w_e_next;

  logic              r_en, r_irq_en, r_done;
  logic [OPW-1:0]    r_opa, r_opb, r_x, r_y;
  logic [OPW-1:0]    w_x_next, w_y_next;
  logic [OPW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pslverr;

  logic [IW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_err, w_access, w_wr, w_rd;
  logic              w_busy, w_empty, w_full;
  logic              w_start, w_clr, w_pop, w_w1c;
  logic              w_push, w_fifo_we;
  logic [OPW-1:0]    w_push_data;
  logic              w_unused;

  assign w_idx    = bus.i_paddr[ADDR_W-1:2];
  assign w_busy   = (r_e_state == E_CALC);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));

  // Byte-lane bits of the address and the unused upper data bits are
  // intentionally ignored.
  assign w_unused = ^{bus.i_paddr[1:0], bus.i_pwdata};

  // ---------------------------------------------------------------- APB FSM
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_apb_state <= IDLE;
    else     r_apb_state <= w_apb_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_apb_next = r_apb_state;
    case (r_apb_state)
      IDLE:    if (bus.i_psel) w_apb_next = ACCESS;
      ACCESS: begin
        if (!bus.i_psel)         w_apb_next = IDLE;
        else if (bus.i_penable)  w_apb_next = DONE;
      end
      DONE:    w_apb_next = IDLE;
      default: w_apb_next = IDLE;
    endcase
  end

  // The access (side effects, read capture) happens on the ACCESS->DONE edge;
  // DONE then presents the registered response for exactly one cycle.
  assign w_access = (r_apb_state == ACCESS) && bus.i_psel && bus.i_penable;
  assign w_wr     = w_access && !w_err &&  bus.i_pwrite;
  assign w_rd     = w_access && !w_err && !bus.i_pwrite;

  // ---------------------------------------------------- decode / read mux
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_idx)
      A_CTRL:   w_rdata[1:0] = {r_irq_en, r_en};
      A_STATUS: begin
        w_err           = bus.i_pwrite;
        w_rdata[0]      = w_busy;
        w_rdata[1]      = w_empty;
        w_rdata[2]      = w_full;
        w_rdata[8 +: CW] = r_count;
      end
      A_OPA:    w_rdata[OPW-1:0] = r_opa;
      A_OPB:    w_rdata[OPW-1:0] = r_opb;
      // A rejected START is an error; a CMD write with START=0 is a no-op.
      A_CMD:    w_err = !bus.i_pwrite ||
                        (bus.i_pwdata[0] && (w_busy || !r_en || w_full));
      A_RESULT: begin
        w_err = bus.i_pwrite || w_empty;
        if (!w_empty) w_rdata[OPW-1:0] = r_mem[r_rptr];
      end
      A_IRQ:    w_rdata[0] = r_done;
      default:  w_err = 1'b1;
    endcase
  end

  assign w_start = w_wr && (w_idx == A_CMD)  && bus.i_pwdata[0];
  assign w_clr   = w_wr && (w_idx == A_CTRL) && bus.i_pwdata[2];
  assign w_w1c   = w_wr && (w_idx == A_IRQ)  && bus.i_pwdata[0];
  assign w_pop   = w_rd && (w_idx == A_RESULT);

  // Error responses always carry zero data; both outputs fall back to zero
  // as the FSM leaves DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_prdata  <= w_rd ? w_rdata : '0;
      r_pslverr <= w_access && w_err;
    end
  end

  assign bus.o_prdata  = r_prdata;
  assign bus.o_pslverr = r_pslverr;
  assign bus.o_pready  = (r_apb_state == DONE);

  // ------------------------------------------------------- control regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_wr && (w_idx == A_CTRL)) begin
        r_en     <= bus.i_pwdata[0];
        r_irq_en <= bus.i_pwdata[1];
      end
      if (w_wr && (w_idx == A_OPA)) r_opa <= bus.i_pwdata[OPW-1:0];
      if (w_wr && (w_idx == A_OPB)) r_opb <= bus.i_pwdata[OPW-1:0];
      // A completion landing in the same cycle as the W1C wins.
      r_done <= w_push || (r_done && !w_w1c);
    end
  end

  assign o_irq = r_done && r_irq_en;

  // ---------------------------------------------------------- GCD engine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_state <= E_IDLE;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_e_state <= w_e_next;
      r_x       <= w_x_next;
      r_y       <= w_y_next;
    end
  end

  always_comb begin
    w_e_next    = r_e_state;
    w_x_next    = r_x;
    w_y_next    = r_y;
    w_push      = 1'b0;
    w_push_data = '0;
    case (r_e_state)
      E_IDLE: begin
        // Operands are snapshotted so later OPA/OPB writes cannot disturb
        // a calculation in flight.
        if (w_start) begin
          w_e_next = E_CALC;
          w_x_next = r_opa;
          w_y_next = r_opb;
        end
      end
      E_CALC: begin
        if (!r_en) begin
          w_e_next = E_IDLE;
        end else if (r_x == '0) begin
          w_push      = 1'b1;
          w_push_data = r_y;
          w_e_next    = E_IDLE;
        end else if ((r_y == '0) || (r_x == r_y)) begin
          w_push      = 1'b1;
          w_push_data = r_x;
          w_e_next    = E_IDLE;
        end else if (r_x > r_y) begin
          w_x_next = r_x - r_y;
        end else begin
          w_y_next = r_y - r_x;
        end
      end
      default: w_e_next = E_IDLE;
    endcase
  end

  // ---------------------------------------------------------- result FIFO
  // FIFO_CLR drops a same-cycle push; START is refused when full, so the
  // full guard only protects against a clear/refill race.
  assign w_fifo_we = w_push && !w_clr && (!w_full || w_pop);

  // NOTE: the storage array is deliberately not reset; COUNT and the
  // pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_fifo_we) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_fifo_we) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      case ({w_fifo_we, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gcd_engine.sv
// ----------------------------------------------------------------------------
// tb_apb_gcd_engine -- directed self-checking bench for apb_gcd_engine
// (default parameters: ADDR_W=8, DATA_W=32, OPW=16, DEPTH=4).
// ----------------------------------------------------------------------------
module tb_apb_gcd_engine;

  logic clk;
  logic rst;
  logic o_irq;

  apb_gcd_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_gcd_engine #(.ADDR_W(8), .DATA_W(32), .OPW(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .o_irq (o_irq)
  );

  localparam logic [7:0] CTRL   = 8'h00;
  localparam logic [7:0] STATUS = 8'h04;
  localparam logic [7:0] OPA    = 8'h08;
  localparam logic [7:0] OPB    = 8'h0C;
  localparam logic [7:0] CMD    = 8'h10;
  localparam logic [7:0] RESULT = 8'h14;
  localparam logic [7:0] IRQ    = 8'h18;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic        er;
  int          cyc;
  time         t_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; response sampled 1 time unit after the edge that
  // raised o_pready, then the bus is released after the completing edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    bus.i_paddr   = addr;
    bus.i_pwrite  = wr;
    bus.i_pwdata  = wd;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    @(posedge clk); #1;
    bus.i_penable = 1'b1;
    n = 2;
    while (!bus.o_pready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rd    = bus.o_prdata;
    er    = bus.o_pslverr;
    cyc   = n;
    t_acc = $time;
    @(posedge clk); #1;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic exp_err);
    apb(1'b1, a, d);
    check({tag, " pslverr"}, er, exp_err);
    check({tag, " cycles"}, cyc, 3);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic exp_err);
    apb(1'b0, a, 32'h0);
    check({tag, " prdata"}, rd, exp_d);
    check({tag, " pslverr"}, er, exp_err);
    check({tag, " cycles"}, cyc, 3);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!o_irq && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " irq"}, o_irq, 1'b1);
  endtask

  // Edges from the START access edge to the push that raised DONE.
  function automatic int calc_cycles();
    return int'(($time - t_acc) / 10);
  endfunction

  initial begin
    rst           = 1'b1;
    bus.i_paddr   = '0;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = 1'b0;
    bus.i_pwdata  = '0;
    #12;
    check("reset pready", bus.o_pready, 1'b0);
    check("reset prdata", bus.o_prdata, 32'h0);
    check("reset pslverr", bus.o_pslverr, 1'b0);
    check("reset irq", o_irq, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd_chk("status after reset", STATUS, 32'h0000_0002, 1'b0);
    rd_chk("ctrl after reset", CTRL, 32'h0, 1'b0);

    // gcd(12,8): 12-8=4, 8-4=4, equal -> push 4 after 3 calc cycles
    wr("ctrl en+irq", CTRL, 32'h3, 1'b0);
    wr("opa 12", OPA, 32'd12, 1'b0);
    wr("opb 8", OPB, 32'd8, 1'b0);
    wr("start 12 8", CMD, 32'h1, 1'b0);
    wait_irq("gcd 12 8");
    check("gcd 12 8 busy cycles", calc_cycles(), 3);
    rd_chk("status count 1", STATUS, 32'h0000_0100, 1'b0);
    rd_chk("irq reg done", IRQ, 32'h1, 1'b0);
    rd_chk("result 12 8", RESULT, 32'd4, 1'b0);
    check("idle prdata", bus.o_prdata, 32'h0);
    check("idle pready", bus.o_pready, 1'b0);
    rd_chk("status drained", STATUS, 32'h0000_0002, 1'b0);
    wr("irq w1c", IRQ, 32'h1, 1'b0);
    check("irq cleared", o_irq, 1'b0);

    // zero operands finish in one calc cycle
    wr("opa 0", OPA, 32'd0, 1'b0);
    wr("opb 9", OPB, 32'd9, 1'b0);
    wr("start 0 9", CMD, 32'h1, 1'b0);
    wait_irq("gcd 0 9");
    check("gcd 0 9 cycles", calc_cycles(), 1);
    wr("irq w1c 2", IRQ, 32'h1, 1'b0);
    wr("opb 0", OPB, 32'd0, 1'b0);
    wr("start 0 0", CMD, 32'h1, 1'b0);
    wait_irq("gcd 0 0");
    check("gcd 0 0 cycles", calc_cycles(), 1);
    rd_chk("result 0 9", RESULT, 32'd9, 1'b0);
    rd_chk("result 0 0", RESULT, 32'd0, 1'b0);
    rd_chk("result empty", RESULT, 32'd0, 1'b1);
    wr("irq w1c 3", IRQ, 32'h1, 1'b0);
    wr("opa 7", OPA, 32'd7, 1'b0);
    wr("start 7 0", CMD, 32'h1, 1'b0);
    wait_irq("gcd 7 0");
    check("gcd 7 0 cycles", calc_cycles(), 1);
    rd_chk("result 7 0", RESULT, 32'd7, 1'b0);

    // OPA rewritten mid-calculation: gcd(96,6)=6 still expected
    wr("irq w1c 4", IRQ, 32'h1, 1'b0);
    wr("opa 96", OPA, 32'd96, 1'b0);
    wr("opb 6", OPB, 32'd6, 1'b0);
    wr("start 96 6", CMD, 32'h1, 1'b0);
    rd_chk("status busy", STATUS, 32'h0000_0003, 1'b0);
    wr("opa 7 while busy", OPA, 32'd7, 1'b0);
    wait_irq("gcd 96 6");
    rd_chk("result 96 6", RESULT, 32'd6, 1'b0);
    rd_chk("opa readback", OPA, 32'd7, 1'b0);

    // fill FIFO with DEPTH results, the extra START is refused
    wr("opa ffff", OPA, 32'h0000_FFFF, 1'b0);
    wr("opb ffff", OPB, 32'h0000_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) wr("fill start", CMD, 32'h1, 1'b0);
    wr("start when full", CMD, 32'h1, 1'b1);
    rd_chk("status full", STATUS, 32'h0000_0404, 1'b0);
    for (int i = 0; i < 4; i++) rd_chk("result full drain", RESULT, 32'h0000_FFFF, 1'b0);
    rd_chk("result after drain", RESULT, 32'h0, 1'b1);

    // FIFO_CLR empties the queue and reads back as 0
    wr("refill 1", CMD, 32'h1, 1'b0);
    wr("refill 2", CMD, 32'h1, 1'b0);
    rd_chk("status count 2", STATUS, 32'h0000_0200, 1'b0);
    wr("fifo clr", CTRL, 32'h7, 1'b0);
    rd_chk("status after clr", STATUS, 32'h0000_0002, 1'b0);
    rd_chk("ctrl after clr", CTRL, 32'h3, 1'b0);

    // abort by clearing EN: no push, DONE stays clear
    wr("irq w1c 5", IRQ, 32'h1, 1'b0);
    wr("opa 1000", OPA, 32'd1000, 1'b0);
    wr("opb 1", OPB, 32'd1, 1'b0);
    wr("start 1000 1", CMD, 32'h1, 1'b0);
    rd_chk("status long busy", STATUS, 32'h0000_0003, 1'b0);
    wr("ctrl clear en", CTRL, 32'h2, 1'b0);
    rd_chk("status after abort", STATUS, 32'h0000_0002, 1'b0);
    check("irq after abort", o_irq, 1'b0);
    wr("start with en 0", CMD, 32'h1, 1'b1);
    rd_chk("status no start", STATUS, 32'h0000_0002, 1'b0);
    wr("ctrl re-enable", CTRL, 32'h3, 1'b0);

    // error responses leave registers untouched
    rd_chk("read unmapped", 8'h1C, 32'h0, 1'b1);
    wr("write status", STATUS, 32'hFFFF_FFFF, 1'b1);
    rd_chk("read cmd", CMD, 32'h0, 1'b1);
    wr("write result", RESULT, 32'h0000_1234, 1'b1);
    rd_chk("status unchanged", STATUS, 32'h0000_0002, 1'b0);
    rd_chk("ctrl unchanged", CTRL, 32'h3, 1'b0);
    rd_chk("opa unchanged", OPA, 32'd1000, 1'b0);
    rd_chk("opb unchanged", OPB, 32'd1, 1'b0);

    // reset during a calculation and an in-flight read, COUNT=2
    wr("opa ffff b", OPA, 32'h0000_FFFF, 1'b0);
    wr("opb ffff b", OPB, 32'h0000_FFFF, 1'b0);
    wr("pre-reset push 1", CMD, 32'h1, 1'b0);
    wr("pre-reset push 2", CMD, 32'h1, 1'b0);
    wr("opa 1000 b", OPA, 32'd1000, 1'b0);
    wr("opb 1 b", OPB, 32'd1, 1'b0);
    wr("start before reset", CMD, 32'h1, 1'b0);
    @(posedge clk); #1;
    bus.i_paddr   = STATUS;
    bus.i_pwrite  = 1'b0;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    @(posedge clk); #1;
    bus.i_penable = 1'b1;
    @(posedge clk); #1;
    check("inflight pready", bus.o_pready, 1'b1);
    check("inflight status", bus.o_prdata, 32'h0000_0201);
    check("irq before reset", o_irq, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async reset pready", bus.o_pready, 1'b0);
    check("async reset prdata", bus.o_prdata, 32'h0);
    check("async reset pslverr", bus.o_pslverr, 1'b0);
    check("async reset irq", o_irq, 1'b0);
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("status after mid reset", STATUS, 32'h0000_0002, 1'b0);
    rd_chk("ctrl after mid reset", CTRL, 32'h0, 1'b0);
    rd_chk("opa after mid reset", OPA, 32'h0, 1'b0);
    rd_chk("irq reg after mid reset", IRQ, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gcd_engine.md
APB_GCD_ENGINE -- requirements
Module: apb_gcd_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter OPW, default 16, operand/result width, legal range 2..DATA_W.
REQ-004 The block SHALL have parameter DEPTH, default 4, result FIFO depth, power of 2 and at least 2; CW = clog2(DEPTH+1).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 The block SHALL have port i_paddr, input, ADDR_W, APB address.
REQ-008 The block SHALL have ports i_psel, i_penable and i_pwrite, input, 1 each, APB select, enable and write.
REQ-009 The block SHALL have port i_pwdata, input, DATA_W, APB write data.
REQ-010 The block SHALL have port o_prdata, output, DATA_W, APB read data.
REQ-011 The block SHALL have ports o_pready and o_pslverr, output, 1 each, APB ready and error.
REQ-012 The block SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-013 Register map, decoded on i_paddr[ADDR_W-1:2]:
- 0x00 CTRL RW: [0] EN, [1] IRQ_EN, [2] FIFO_CLR (write-1 pulse, reads 0).
- 0x04 STATUS RO: [0] BUSY, [1] EMPTY, [2] FULL, [8+:CW] COUNT.
- 0x08 OPA RW [OPW-1:0]; 0x0C OPB RW [OPW-1:0].
- 0x10 CMD WO: [0] START.
- 0x14 RESULT RO: read pops the FIFO.
- 0x18 IRQ RW1C: [0] DONE.
- Unused data bits SHALL read 0.
REQ-014 APB FSM SHALL have states IDLE, ACCESS and DONE.
- IDLE: i_psel=1 moves to ACCESS.
- ACCESS: first cycle with i_psel&i_penable performs the access and moves to DONE.
- DONE: o_pready=1 for exactly one cycle, then IDLE.
- Each transfer has exactly one wait state.
REQ-015 o_prdata and o_pslverr SHALL be registered and valid only while o_pready=1; otherwise both SHALL be 0.
REQ-016 The block SHALL set o_pslverr=1 for any of:
- an unmapped address;
- a write to STATUS or RESULT;
- a read of CMD;
- a RESULT read while the FIFO is empty (o_prdata=0, no pop);
- START=1 while BUSY=1, EN=0 or FULL=1 (ignored).
Errored accesses SHALL have no side effects.
REQ-017 Engine FSM SHALL have states E_IDLE and E_CALC. An accepted START SHALL copy OPA/OPB into working registers x/y and enter E_CALC; BUSY=1 in E_CALC.
REQ-018 Each E_CALC cycle SHALL evaluate in priority order:
- x==0: push y;
- y==0: push x;
- x==y: push x;
- x>y: x<=x-y;
- else y<=y-x.
A push SHALL return the engine to E_IDLE.
REQ-019 All engine arithmetic SHALL be unsigned OPW-bit; gcd(0,0)=0. Results SHALL be zero-extended to DATA_W on read.
REQ-020 Clearing EN during E_CALC SHALL abort to E_IDLE on the next edge with no push.
REQ-021 FIFO SHALL be first-word-first-out with wrapping pointers and COUNT 0..DEPTH. A simultaneous push and pop SHALL leave COUNT unchanged.
REQ-022 FIFO_CLR SHALL zero COUNT and pointers in the write cycle; it SHALL override a same-cycle push, and the engine state is unaffected.
REQ-023 Each push SHALL set IRQ.DONE. A same-cycle set and W1C SHALL leave DONE=1.
REQ-024 o_irq SHALL equal DONE & IRQ_EN, driven combinationally from registers.
REQ-025 OPA/OPB writes during BUSY SHALL update the registers only and SHALL NOT disturb the calculation in flight.

Reset
REQ-026 While rst=1 all state SHALL asynchronously clear:
- APB FSM=IDLE, engine=E_IDLE;
- CTRL, OPA, OPB, DONE, FIFO pointers and COUNT = 0;
- o_prdata=0, o_pready=0, o_pslverr=0, o_irq=0.
After reset STATUS SHALL read 0x00000002.
REQ-027 Deassertion of rst SHALL take effect on the next clk edge; a transfer in flight at reset SHALL be discarded.

Verification
REQ-028 Write CTRL=0x3, OPA=12, OPB=8, CMD=1 -> BUSY for exactly 3 cycles, then COUNT=1, o_irq=1, RESULT read=4 with pslverr=0.
REQ-029 Run START for (0,9) and (0,0) -> each completes in 1 E_CALC cycle; reads return 9 then 0.
REQ-030 With OPW=16, run DEPTH+1 STARTs of (65535,1) without reads -> the last START returns pslverr=1; FULL=1, COUNT=DEPTH; RESULT reads return 1 DEPTH times, then one errored read with prdata=0.
REQ-031 START (1000,1) and clear EN after 10 cycles -> BUSY=0 next cycle, COUNT unchanged, DONE unchanged.
REQ-032 Read unmapped 0x1C, write STATUS, read CMD -> pslverr=1 each, every access 3 cycles, registers unchanged.
REQ-033 Assert rst mid-calculation with COUNT=2 -> all outputs 0 immediately; STATUS then reads 0x00000002.
